sequencer_ctrl: RTL and testbench

Control FSM for the step sequencer. It owns the single-port step memory, which is shared between two requesters: the playback reader, paced by an internal step timer, and the user write path, driven by debounced set requests. It advances the step pointer, arbitrates memory reads and writes, and latches the current step's pattern onto the LEDs. It sits between the debouncers/edge detectors and the step RAM inside sequencer_top.

---
 rtl/sequencer_pkg.sv | 19 +
 rtl/step_timer.sv | 33 +++
 rtl/sequencer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sequencer_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared definitions for the step sequencer control path.
//   - state_e        : control FSM state encoding
//   - DefDataW       : default pattern width (one bit per LED)
//   - DefAddrW       : default step memory address width
//   - DefNumSteps    : default number of sequence steps
package sequencer_pkg;

    localparam int unsigned DefDataW    = 2;
    localparam int unsigned DefAddrW    = 3;
    localparam int unsigned DefNumSteps = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRdAddr,
        StRdData
    } state_e;

endpackage

// File: rtl/step_timer.sv
// Free-running step timer: counts 0..STEP_COUNTS-1 and raises tick_o for the
// single cycle in which the count sits at its terminal value.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (count returns to 0)
//   tick_o  : one-cycle pulse once every STEP_COUNTS cycles
module step_timer #(
    parameter int unsigned STEP_COUNTS = 1200000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CntW = (STEP_COUNTS > 1) ? $clog2(STEP_COUNTS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STEP_COUNTS - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        tick_o  = (count_q == CntMax);
        count_d = tick_o ? '0 : count_q + CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sequencer_ctrl.sv
// Step sequencer control: advances the step pointer on every timer tick,
// arbitrates the single-port step memory between playback reads and user
// writes (writes first), and latches the current step pattern onto the LEDs.
// Ports:
//   clk        : system clock
//   rst_btn    : asynchronous active-low reset
//   set_req    : one-cycle request to store set_data at the current step
//   set_data   : pattern to store, sampled with set_req
//   set_ack    : one-cycle pulse in the cycle the write reaches memory
//   mem_addr   : step memory address
//   mem_we     : step memory write enable
//   mem_re     : step memory read enable
//   mem_wdata  : step memory write data
//   mem_rdata  : step memory read data, valid the cycle after mem_re
//   led        : pattern of the current step
//   step_idx   : current step pointer
module sequencer_ctrl
    import sequencer_pkg::*;
#(
    parameter int unsigned STEP_COUNTS = 1200000,
    parameter int unsigned NUM_STEPS   = DefNumSteps,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW
) (
    input  logic              clk,
    input  logic              rst_btn,
    input  logic              set_req,
    input  logic [DATA_W-1:0] set_data,
    output logic              set_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] led,
    output logic [ADDR_W-1:0] step_idx
);

    localparam logic [ADDR_W-1:0] LastStep = ADDR_W'(NUM_STEPS - 1);

    logic tick;

    state_e            state_q, state_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] step_idx_q, step_idx_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              set_ack_q, set_ack_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    step_timer #(
        .STEP_COUNTS(STEP_COUNTS)
    ) u_step_timer (
        .clk_i (clk),
        .rst_ni(rst_btn),
        .tick_o(tick)
    );

    always_comb begin
        state_d     = state_q;
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        step_idx_d  = step_idx_q;
        led_d       = led_q;
        set_ack_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (tick) begin
            step_idx_d = (step_idx_q == LastStep) ? '0 : step_idx_q + ADDR_W'(1);
        end

        // Memory strobes and address/data are registered from the next state,
        // so they are valid during the cycle the FSM occupies WR / RD_ADDR.
        case (state_q)
            StIdle: begin
                if (wr_pend_q) begin
                    state_d   = StWr;
                    mem_we_d  = 1'b1;
                    set_ack_d = 1'b1;
                    // A request landing in this same cycle replaces the pending
                    // one, so forward it to keep a single write with the latest data.
                    mem_addr_d  = set_req ? step_idx_q : wr_addr_q;
                    mem_wdata_d = set_req ? set_data : wr_data_q;
                end else if (rd_pend_q) begin
                    state_d    = StRdAddr;
                    mem_re_d   = 1'b1;
                    // Use the post-tick pointer so a coincident tick is not read stale.
                    mem_addr_d = step_idx_d;
                end
            end
            StWr: begin
                wr_pend_d = 1'b0;
                if (wr_addr_q == step_idx_q) begin
                    rd_pend_d = 1'b1;
                end
                state_d = StIdle;
            end
            StRdAddr: begin
                rd_pend_d = 1'b0;
                state_d   = StRdData;
            end
            StRdData: begin
                led_d   = mem_rdata;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // New events override the clears above.
        if (tick) begin
            rd_pend_d = 1'b1;
        end
        if (set_req) begin
            wr_pend_d = 1'b1;
            wr_addr_d = step_idx_q;
            wr_data_d = set_data;
        end
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q     <= StIdle;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b1;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            step_idx_q  <= '0;
            led_q       <= '0;
            set_ack_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            step_idx_q  <= step_idx_d;
            led_q       <= led_d;
            set_ack_q   <= set_ack_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign set_ack   = set_ack_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign led       = led_q;
    assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_sequencer_ctrl.sv
// Directed bench for sequencer_ctrl with STEP_COUNTS=10 and a 1-cycle-latency
// step RAM preloaded with mem[k] = k[1:0].
module tb_sequencer_ctrl;

    logic       clk;
    logic       rst_btn;
    logic       set_req;
    logic [1:0] set_data;
    logic       set_ack;
    logic [2:0] mem_addr;
    logic       mem_we;
    logic       mem_re;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata = 2'd0;
    logic [1:0] led;
    logic [2:0] step_idx;

    logic [1:0] ram [0:7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int ack_cnt  = 0;
    logic [2:0] last_waddr = 3'd0;
    logic [1:0] last_wdata = 2'd0;
    int we0, re0, ack0;

    sequencer_ctrl #(
        .STEP_COUNTS(10),
        .NUM_STEPS  (8),
        .ADDR_W     (3),
        .DATA_W     (2)
    ) dut (
        .clk      (clk),
        .rst_btn  (rst_btn),
        .set_req  (set_req),
        .set_data (set_data),
        .set_ack  (set_ack),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .led      (led),
        .step_idx (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step RAM model: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Mid-cycle monitor: strobe exclusivity plus write/read/ack accounting.
    always @(negedge clk) begin
        if (rst_btn) begin
            n_checks++;
            assert (!(mem_we && mem_re)) else begin
                n_fail++;
                $error("FAIL we_re_exclusive: observed we=%0b re=%0b, required not both 1",
                       mem_we, mem_re);
            end
            if (mem_we) begin
                we_cnt++;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
            end
            if (mem_re) re_cnt++;
            if (set_ack) ack_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after posedge number 'target' since the last reset release.
    task automatic go_to(input int target);
        while (edge_cnt < target) begin
            @(posedge clk);
            edge_cnt++;
        end
        #1;
    endtask

    initial begin
        rst_btn  = 1'b1;
        set_req  = 1'b0;
        set_data = 2'd0;
        #2 rst_btn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_led", led, 0);
        check("rst_step", step_idx, 0);
        check("rst_ack", set_ack, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_btn  = 1'b1;
        edge_cnt = 0;

        // 1: initial read of step 0, then playback through a full wrap.
        go_to(1);
        check("init_re", mem_re, 1);
        go_to(3);
        check("init_led", led, 0);
        check("init_step", step_idx, 0);
        for (int s = 1; s <= 8; s++) begin
            go_to(10 * s + 2);
            check("play_step", step_idx, s % 8);
            check("play_led_hold", led, (s - 1) % 4);
            go_to(10 * s + 3);
            check("play_led", led, (s % 8) % 4);
        end

        // 2: write 3 at step 5 while idle.
        go_to(133);
        check("t2_led_pre", led, 1);
        we0 = we_cnt; ack0 = ack_cnt;
        set_req = 1'b1; set_data = 2'd3;
        go_to(134);
        set_req = 1'b0;
        check("t2_ack_early", set_ack, 0);
        go_to(135);
        check("t2_we", mem_we, 1);
        check("t2_ack", set_ack, 1);
        check("t2_addr", mem_addr, 5);
        check("t2_wdata", mem_wdata, 3);
        go_to(136);
        check("t2_ack_pulse", set_ack, 0);
        go_to(139);
        check("t2_led_refresh", led, 3);
        go_to(140);
        check("t2_we_count", we_cnt - we0, 1);
        check("t2_ack_count", ack_cnt - ack0, 1);
        go_to(213);
        check("t2_led_wrap", led, 3);

        // 3: set_req coincident with the tick 2->3.
        go_to(263);
        check("t3_led_pre", led, 2);
        go_to(269);
        we0 = we_cnt; re0 = re_cnt;
        set_req = 1'b1; set_data = 2'b10;
        go_to(270);
        set_req = 1'b0;
        check("t3_step", step_idx, 3);
        go_to(271);
        check("t3_we", mem_we, 1);
        check("t3_addr", mem_addr, 2);
        check("t3_wdata", mem_wdata, 2);
        go_to(275);
        check("t3_led", led, 3);
        go_to(280);
        check("t3_we_count", we_cnt - we0, 1);
        check("t3_re_count", re_cnt - re0, 1);

        // 4: back-to-back requests coalesce into one write of the later data.
        go_to(293);
        check("t4_led_pre", led, 3);
        go_to(294);
        we0 = we_cnt; ack0 = ack_cnt;
        set_req = 1'b1; set_data = 2'b01;
        go_to(295);
        set_data = 2'b10;
        go_to(296);
        set_req = 1'b0;
        check("t4_we", mem_we, 1);
        check("t4_wdata", mem_wdata, 2);
        go_to(298);
        check("t4_we_count", we_cnt - we0, 1);
        check("t4_ack_count", ack_cnt - ack0, 1);
        check("t4_last_addr", last_waddr, 5);
        check("t4_last_wdata", last_wdata, 2);
        go_to(300);
        check("t4_led", led, 2);

        // 5: request during RD_ADDR: read completes, then write, then refresh.
        go_to(311);
        check("t5_re", mem_re, 1);
        check("t5_rd_addr", mem_addr, 7);
        set_req = 1'b1; set_data = 2'b01;
        go_to(312);
        set_req = 1'b0;
        go_to(313);
        check("t5_led_read_first", led, 3);
        check("t5_we_wait", mem_we, 0);
        go_to(314);
        check("t5_we", mem_we, 1);
        check("t5_ack", set_ack, 1);
        check("t5_addr", mem_addr, 7);
        check("t5_wdata", mem_wdata, 1);
        go_to(316);
        check("t5_refresh_re", mem_re, 1);
        go_to(318);
        check("t5_led_refresh", led, 1);

        // 6: asynchronous reset in the middle of a write.
        go_to(333);
        check("t6_led_pre", led, 1);
        go_to(334);
        set_req = 1'b1; set_data = 2'd3;
        go_to(335);
        set_req = 1'b0;
        go_to(336);
        check("t6_we", mem_we, 1);
        check("t6_addr", mem_addr, 1);
        #2 rst_btn = 1'b0;
        #1;
        check("t6_we_clr", mem_we, 0);
        check("t6_ack_clr", set_ack, 0);
        check("t6_led_clr", led, 0);
        check("t6_step_clr", step_idx, 0);
        check("t6_addr_clr", mem_addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_no_commit", ram[1], 1);
        rst_btn  = 1'b1;
        edge_cnt = 0;
        go_to(3);
        check("t6_post_led", led, 0);
        check("t6_post_step", step_idx, 0);
        go_to(13);
        check("t6_post_step1", step_idx, 1);
        check("t6_post_led1", led, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
